canny_line_buffer: RTL and testbench
====================================

# canny_line_buffer

Three-line delay buffer sitting directly upstream of the Canny shifter block. It accepts one 64-bit memory word (four 16-bit pixels) per strobe on `q1`. For every accepted word it presents the words at the same column from the previous three image lines on `BufferA` (one line above), `BufferB` (two above) and `BufferC` (three above). The shifter pairs these with `q1` to build its four-row pixel window.

## Interface

Parameters:
- `LINEWORDS`, 512 — 64-bit words per image line (2048 px / 4).
- `PTRW`, 9 — column pointer width; must satisfy 2^PTRW >= LINEWORDS.

Ports:
- `clk`  input  1  — single clock; all state updates on rising edge.
- `reset`  input  1  — asynchronous, active-low reset; clears all registers below.
- `frameStart`  input  1  — synchronous; restarts the frame at column 0, line 0.
- `wrEn`  input  1  — `q1` carries a valid word this cycle.
- `q1`  input  64  — incoming pixel word, pixel 0 in bits [15:0].
- `BufferA`  output  64  — same-column word, line N-1.
- `BufferB`  output  64  — same-column word, line N-2.
- `BufferC`  output  64  — same-column word, line N-3.
- `bufValid`  output  1  — one-cycle pulse; `Buffer*` updated this cycle.
- `primed`  output  1  — high once three full lines are stored.
- `colPtr`  output  PTRW  — column of the next word to be accepted.

## Operation

- Storage: three line memories `memA`, `memB`, `memC`, each LINEWORDS x 64, plus a registered `lineCount` (2 bits, saturating at 3).
- Accepted word at column p (`wrEn`=1), one read-before-write access to all three memories at address p:
  - `BufferA`<=`memA[p]`, `BufferB`<=`memB[p]`, `BufferC`<=`memC[p]` (pre-write values).
  - `memC[p]`<=`memB[p]`, `memB[p]`<=`memA[p]`, `memA[p]`<=`q1`.
- Output masking, evaluated on `lineCount` before the update: `BufferA` is forced to 0 if `lineCount`<1, `BufferB` if <2, `BufferC` if <3. Stale memory content never reaches the outputs.
- Column pointer: `colPtr` increments per accepted word. At LINEWORDS-1 it wraps to 0 and `lineCount` increments, saturating at 3.
- `primed` = (`lineCount`==3).
- `wrEn`=0: no memory write; outputs and pointer hold; `bufValid`=0.

## Timing

- Latency: word accepted on edge k; `Buffer*` valid and `bufValid`=1 after edge k, i.e. during cycle k+1. Outputs then hold until the next accepted word, which gives the shifter's falling-edge capture a full stable half-cycle.
- Throughput: one word per cycle, back-to-back `wrEn` allowed.
- Reset (`reset`=0, any time, including mid-line):
  - `Buffer*`=0, `bufValid`=0, `colPtr`=0, `lineCount`=0, `primed`=0.
  - Memories are not cleared; masking covers their contents.
- `frameStart`=1: `colPtr`<=0, `lineCount`<=0, `bufValid`<=0; outputs hold.
- `frameStart` together with `wrEn`:
  - The pointer/count clear takes priority.
  - The word is written at address 0 as line 0, column 0.
  - Outputs update to all-zero, `bufValid`=1, `colPtr`<=1.
- Wrap on the last column: the edge that accepts column LINEWORDS-1 also increments `lineCount`. The next accepted word already sees the new count for masking.
- `lineCount` at 3 with a wrap: it stays 3; no overflow.

## Structure

- Shared package `canny_pkg`:
  - `WORDW`=64, `PIXW`=16, `PIXPERWORD`=4.
  - Default `LINEWORDS`.
  - These are also used by the shifter and beat counter.
- Sub-module `canny_line_ram`: single-port read-before-write memory, LINEWORDS x WORDW, registered read data. It is instantiated three times, with the chaining wired at top level.
- Top level holds pointer, line counter, masking and `bufValid`.

## Test plan

- Benches use LINEWORDS=4.
- Reset then four words 0x1..0x4 with `wrEn` held high:
  - `bufValid` pulses 4 times; all `Buffer*`=0.
  - `colPtr` wraps to 0; `primed`=0.
- Lines 0..3 with words = 0x100·line+col, after priming:
  - Word (line 3, col 2) gives `BufferA`=0x202, `BufferB`=0x102, `BufferC`=0x002.
  - `primed`=1 from the first word of line 3.
- `wrEn` gaps of 0-3 idle cycles inserted randomly: outputs identical to the gapless run; outputs hold during gaps.
- Assert `reset` low mid-line 2:
  - Outputs 0 and `colPtr`=0 immediately, without waiting for a clock edge.
  - The next two lines show masked zeros on `BufferB`/`BufferC` despite stale memory.
- `frameStart` with `wrEn` at col 3 of line 3:
  - Outputs 0, `colPtr`=1, `primed`=0.
  - Refilling reproduces the expected values.
- Seven lines streamed: `lineCount` saturates and `primed` stays 1. Every output matches a software model that keeps three line-delay queues.

Source files
------------

// File: rtl/canny_pkg.sv
// Shared constants and types for the Canny front end (line buffer, shifter, beat counter).
package canny_pkg;

   localparam int unsigned WORDW         = 64;
   localparam int unsigned PIXW          = 16;
   localparam int unsigned PIXPERWORD    = 4;
   localparam int unsigned LINEWORDS_DEF = 512;
   localparam int unsigned PTRW_DEF      = 9;
   localparam int unsigned NLINES        = 3;
   localparam int unsigned CNTW          = 2;

   typedef logic [WORDW-1:0] word_t;
   typedef logic [CNTW-1:0]  line_cnt_t;

   localparam line_cnt_t LINES_FULL = CNTW'(NLINES);

   // Count of fully stored lines, saturating once all delay lines hold data.
   function automatic line_cnt_t line_cnt_inc(input line_cnt_t cnt);
      return (cnt == LINES_FULL) ? cnt : cnt + CNTW'(1);
   endfunction

endpackage

// File: rtl/canny_line_ram.sv
// Single-port read-before-write line memory with a registered, maskable read port.
// The pre-write word is also exposed combinationally so lines can be chained.
module canny_line_ram
   import canny_pkg::*;
#(
   parameter int unsigned DEPTH = LINEWORDS_DEF,
   parameter int unsigned AW    = PTRW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          rd_zero,
   input  logic [AW-1:0] addr,
   input  word_t         wr_data,
   output word_t         rd_old_c,
   output word_t         rd_data_q
);

   word_t mem [DEPTH];
   word_t rd_data_d;

   // Contents are never cleared; the consumer masks lines not yet written.
   always_ff @(posedge clk) begin
      if (en) begin
         mem[addr] <= wr_data;
      end
   end

   always_comb begin
      rd_old_c = mem[addr];
   end

   always_comb begin
      rd_data_d = rd_data_q;
      if (en) begin
         rd_data_d = rd_zero ? '0 : rd_old_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

endmodule

// File: rtl/canny_line_buffer.sv
// Three-line delay buffer: for each accepted word, presents the same-column
// words from the previous three image lines, masked until those lines exist.
module canny_line_buffer
   import canny_pkg::*;
#(
   parameter int unsigned LINEWORDS = LINEWORDS_DEF,
   parameter int unsigned PTRW      = PTRW_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            frameStart,
   input  logic            wrEn,
   input  logic [WORDW-1:0] q1,
   output logic [WORDW-1:0] BufferA,
   output logic [WORDW-1:0] BufferB,
   output logic [WORDW-1:0] BufferC,
   output logic            bufValid,
   output logic            primed,
   output logic [PTRW-1:0] colPtr
);

   logic [PTRW-1:0]   col_q, col_d, base_col_c;
   line_cnt_t         cnt_q, cnt_d, base_cnt_c;
   logic              valid_q, valid_d;
   logic              primed_q, primed_d;
   logic [NLINES-1:0] mask_c;

   word_t chain_c [NLINES+1];
   word_t rd_q    [NLINES];

   // frameStart restarts the frame before the same-cycle word is placed.
   always_comb begin
      base_col_c = frameStart ? '0 : col_q;
      base_cnt_c = frameStart ? '0 : cnt_q;
      col_d      = base_col_c;
      cnt_d      = base_cnt_c;
      valid_d    = wrEn;
      if (wrEn) begin
         if (base_col_c == PTRW'(LINEWORDS - 1)) begin
            col_d = '0;
            cnt_d = line_cnt_inc(base_cnt_c);
         end else begin
            col_d = base_col_c + PTRW'(1);
         end
      end
      primed_d = (cnt_d == LINES_FULL);
   end

   // Line i above is valid only once more than i full lines are stored.
   always_comb begin
      mask_c = '0;
      for (int unsigned i = 0; i < NLINES; i++) begin
         mask_c[i] = (base_cnt_c <= CNTW'(i));
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_q    <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         primed_q <= 1'b0;
      end else begin
         col_q    <= col_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         primed_q <= primed_d;
      end
   end

   assign chain_c[0] = q1;

   // Each line memory writes what the line above it held at this column.
   for (genvar i = 0; i < NLINES; i++) begin : g_line
      canny_line_ram #(
         .DEPTH (LINEWORDS),
         .AW    (PTRW)
      ) u_ram (
         .clk       (clk),
         .rst_n     (reset),
         .en        (wrEn),
         .rd_zero   (mask_c[i]),
         .addr      (base_col_c),
         .wr_data   (chain_c[i]),
         .rd_old_c  (chain_c[i+1]),
         .rd_data_q (rd_q[i])
      );
   end

   assign BufferA  = rd_q[0];
   assign BufferB  = rd_q[1];
   assign BufferC  = rd_q[2];
   assign bufValid = valid_q;
   assign primed   = primed_q;
   assign colPtr   = col_q;

endmodule

// File: tb/tb_canny_line_buffer.sv
// Scoreboard bench for canny_line_buffer with a short line length.
module tb_canny_line_buffer;
   import canny_pkg::*;

   localparam int unsigned L  = 4;
   localparam int unsigned PW = 2;

   typedef struct {
      logic [63:0]   a;
      logic [63:0]   b;
      logic [63:0]   c;
      logic          primed;
      logic [PW-1:0] col;
   } exp_t;

   logic          clk;
   logic          reset;
   logic          frameStart;
   logic          wrEn;
   logic [63:0]   q1;
   logic [63:0]   BufferA, BufferB, BufferC;
   logic          bufValid;
   logic          primed;
   logic [PW-1:0] colPtr;

   exp_t        sb[$];
   logic [63:0] hist[$];
   exp_t        mon_e;
   logic [63:0] hold_a, hold_b, hold_c;
   int          checks = 0;
   int          errors = 0;
   int          pulses = 0;

   canny_line_buffer #(.LINEWORDS(L), .PTRW(PW)) dut (
      .clk        (clk),
      .reset      (reset),
      .frameStart (frameStart),
      .wrEn       (wrEn),
      .q1         (q1),
      .BufferA    (BufferA),
      .BufferB    (BufferB),
      .BufferC    (BufferC),
      .bufValid   (bufValid),
      .primed     (primed),
      .colPtr     (colPtr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus; the model is a history of all words in the frame.
   task automatic cyc(input bit we, input bit fs, input logic [63:0] d);
      exp_t e;
      int unsigned n;
      wrEn       = we;
      frameStart = fs;
      q1         = d;
      if (fs) hist.delete();
      if (we) begin
         n = hist.size();
         e.a = (n >= L)     ? hist[n - L]     : 64'h0;
         e.b = (n >= 2 * L) ? hist[n - 2 * L] : 64'h0;
         e.c = (n >= 3 * L) ? hist[n - 3 * L] : 64'h0;
         hist.push_back(d);
         e.primed = (hist.size() >= 3 * L);
         e.col    = PW'(hist.size() % L);
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      wrEn       = 1'b0;
      frameStart = 1'b0;
   endtask

   task automatic word(input logic [63:0] d, input bit gaps);
      cyc(1'b1, 1'b0, d);
      if (gaps) repeat ($urandom_range(0, 3)) cyc(1'b0, 1'b0, 64'h0);
   endtask

   task automatic send_line(input int base, input int ln, input bit gaps);
      for (int col = 0; col < int'(L); col++) word(64'(base + 'h100 * ln + col), gaps);
   endtask

   // Monitor: compare on bufValid, otherwise outputs must hold.
   always @(negedge clk) begin
      if (!reset) begin
         hold_a = 64'h0;
         hold_b = 64'h0;
         hold_c = 64'h0;
      end else if (bufValid) begin
         pulses++;
         if (sb.size() == 0) begin
            check("unexpected_valid", 64'(bufValid), 64'h0);
         end else begin
            mon_e = sb.pop_front();
            check("buf_a", BufferA, mon_e.a);
            check("buf_b", BufferB, mon_e.b);
            check("buf_c", BufferC, mon_e.c);
            check("primed", 64'(primed), 64'(mon_e.primed));
            check("col_ptr", 64'(colPtr), 64'(mon_e.col));
            hold_a = mon_e.a;
            hold_b = mon_e.b;
            hold_c = mon_e.c;
         end
      end else begin
         check("hold_a", BufferA, hold_a);
         check("hold_b", BufferB, hold_b);
         check("hold_c", BufferC, hold_c);
      end
   end

   initial begin
      reset = 1'b0; frameStart = 1'b0; wrEn = 1'b0; q1 = 64'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_a", BufferA, 64'h0);
      check("rst_b", BufferB, 64'h0);
      check("rst_c", BufferC, 64'h0);
      check("rst_valid", 64'(bufValid), 64'h0);
      check("rst_col", 64'(colPtr), 64'h0);
      check("rst_primed", 64'(primed), 64'h0);
      reset = 1'b1;

      // First line straight after reset: all outputs masked
      for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 64'(i));
      cyc(1'b0, 1'b0, 64'h0);
      check("t1_pulses", 64'(pulses), 64'd4);
      check("t1_col_wrap", 64'(colPtr), 64'h0);
      check("t1_primed", 64'(primed), 64'h0);

      // Four lines with random gaps, directed check at line 3 col 2
      cyc(1'b0, 1'b1, 64'h0);
      for (int ln = 0; ln < 3; ln++) send_line(0, ln, 1'b1);
      cyc(1'b1, 1'b0, 64'h300);
      check("t2_primed_l3", 64'(primed), 64'h1);
      cyc(1'b1, 1'b0, 64'h301);
      cyc(1'b1, 1'b0, 64'h302);
      check("t2_a", BufferA, 64'h202);
      check("t2_b", BufferB, 64'h102);
      check("t2_c", BufferC, 64'h002);
      check("t2_valid", 64'(bufValid), 64'h1);
      cyc(1'b1, 1'b0, 64'h303);
      cyc(1'b0, 1'b0, 64'h0);

      // Asynchronous reset mid-line 2
      cyc(1'b0, 1'b1, 64'h0);
      send_line('h5000, 0, 1'b0);
      send_line('h5000, 1, 1'b1);
      word(64'h5200, 1'b0);
      word(64'h5201, 1'b0);
      cyc(1'b0, 1'b0, 64'h0);
      reset = 1'b0;
      hist.delete();
      #1;
      check("t3_rst_a", BufferA, 64'h0);
      check("t3_rst_b", BufferB, 64'h0);
      check("t3_rst_c", BufferC, 64'h0);
      check("t3_rst_col", 64'(colPtr), 64'h0);
      check("t3_rst_valid", 64'(bufValid), 64'h0);
      check("t3_rst_primed", 64'(primed), 64'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int ln = 0; ln < 3; ln++) send_line('h7000, ln, 1'b1);

      // frameStart together with wrEn at line 3 col 3
      cyc(1'b0, 1'b1, 64'h0);
      for (int ln = 0; ln < 3; ln++) send_line('h9000, ln, 1'b0);
      for (int col = 0; col < 3; col++) word(64'('h9300 + col), 1'b0);
      check("t4_pre_primed", 64'(primed), 64'h1);
      cyc(1'b1, 1'b1, 64'hDEAD);
      check("t4_a", BufferA, 64'h0);
      check("t4_b", BufferB, 64'h0);
      check("t4_c", BufferC, 64'h0);
      check("t4_col", 64'(colPtr), 64'h1);
      check("t4_primed", 64'(primed), 64'h0);
      check("t4_valid", 64'(bufValid), 64'h1);
      for (int col = 1; col < int'(L); col++) word(64'('hA000 + col), 1'b1);
      for (int ln = 1; ln < 4; ln++) send_line('hA000, ln, 1'b1);

      // Seven lines: count saturates, primed stays high
      cyc(1'b0, 1'b1, 64'h0);
      for (int ln = 0; ln < 7; ln++) send_line('hB000, ln, 1'b1);
      check("t5_primed", 64'(primed), 64'h1);
      check("t5_col", 64'(colPtr), 64'h0);

      repeat (2) cyc(1'b0, 1'b0, 64'h0);
      check("sb_drained", 64'(sb.size()), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
